// File: rtl/bg_tile_line_fetcher.sv
// Background tile line fetcher for the HuC6270 VDC model.
// For each 8-pixel chunk on a scanline it reads the BAT entry, then the
// plane 0/1 and plane 2/3 words of the referenced tile row, and hands the
// four planar bytes plus the palette to the pixel extractor.
module bg_tile_line_fetcher #(
    parameter int VRAM_AW = 16,
    parameter int CNT_W   = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         scroll_x,
    input  logic [8:0]         bg_y,
    input  logic [1:0]         map_w,
    input  logic               map_h,
    input  logic [CNT_W-1:0]   num_chunks,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_rd,
    input  logic               vram_ready,
    input  logic [15:0]        vram_rdata,
    input  logic               vram_rvalid,
    output logic [31:0]        line_bytes,
    output logic [3:0]         palette,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_BAT_REQ,
        S_BAT_WAIT,
        S_P01_REQ,
        S_P01_WAIT,
        S_P23_REQ,
        S_P23_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Per-line parameters latched at start so upstream may change them mid-line
    logic [6:0]       col;
    logic [8:0]       bgy;
    logic [1:0]       mapw;
    logic             maph;
    logic [CNT_W-1:0] nchunks;
    logic [CNT_W-1:0] cnt;
    logic [11:0]      tile_idx;

    // Fine X scroll is applied by the extractor, not here
    logic unused_fine_x;
    assign unused_fine_x = ^scroll_x[2:0];

    logic [6:0]         wmask;
    logic [6:0]         col_n;
    logic [5:0]         row;
    logic [12:0]        row_off;
    logic [VRAM_AW-1:0] bat_addr;
    logic [VRAM_AW-1:0] tile_base;
    logic [VRAM_AW-1:0] tile_hi;

    // BAT and tile-row address arithmetic from the latched line parameters
    always_comb begin
        wmask   = 7'd127;
        row_off = '0;
        case (mapw)
            2'd0:    wmask = 7'd31;
            2'd1:    wmask = 7'd63;
            default: wmask = 7'd127;
        endcase
        col_n = (col + 7'(cnt)) & wmask;
        row   = bgy[8:3] & (maph ? 6'd63 : 6'd31);
        case (mapw)
            2'd0:    row_off = {2'b00, row, 5'b0};
            2'd1:    row_off = {1'b0, row, 6'b0};
            default: row_off = {row, 7'b0};
        endcase
        bat_addr  = VRAM_AW'(row_off) + VRAM_AW'(col_n);
        tile_base = VRAM_AW'({tile_idx, 4'b0}) + VRAM_AW'(bgy[2:0]);
        tile_hi   = tile_base + VRAM_AW'(8);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the request/handshake outputs decoded from state
    always_comb begin
        state_nx  = state;
        vram_rd   = 1'b0;
        vram_addr = '0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (num_chunks == '0) ? S_DONE : S_BAT_REQ;
                end
            end
            S_BAT_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = bat_addr;
                if (vram_ready) state_nx = S_BAT_WAIT;
            end
            S_BAT_WAIT: begin
                if (vram_rvalid) state_nx = S_P01_REQ;
            end
            S_P01_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = tile_base;
                if (vram_ready) state_nx = S_P01_WAIT;
            end
            S_P01_WAIT: begin
                if (vram_rvalid) state_nx = S_P23_REQ;
            end
            S_P23_REQ: begin
                vram_rd   = 1'b1;
                vram_addr = tile_hi;
                if (vram_ready) state_nx = S_P23_WAIT;
            end
            S_P23_WAIT: begin
                if (vram_rvalid) state_nx = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ((cnt + CNT_W'(1)) == nchunks) ? S_DONE : S_BAT_REQ;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Line parameter latch, chunk counter and busy/done flags
    always_ff @(posedge clock) begin
        if (reset) begin
            col     <= '0;
            bgy     <= '0;
            mapw    <= '0;
            maph    <= 1'b0;
            nchunks <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_IDLE && start) begin
                col     <= scroll_x[9:3];
                bgy     <= bg_y;
                mapw    <= map_w;
                maph    <= map_h;
                nchunks <= num_chunks;
                cnt     <= '0;
                busy    <= 1'b1;
            end
            if (state == S_DONE) begin
                busy <= 1'b0;
            end
            if (state == S_EMIT && out_ready) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Capture read replies; rvalid is only honoured in the matching wait state
    always_ff @(posedge clock) begin
        if (reset) begin
            tile_idx   <= '0;
            palette    <= '0;
            line_bytes <= '0;
        end else if (vram_rvalid) begin
            case (state)
                S_BAT_WAIT: begin
                    tile_idx <= vram_rdata[11:0];
                    palette  <= vram_rdata[15:12];
                end
                S_P01_WAIT: line_bytes[15:0]  <= vram_rdata;
                S_P23_WAIT: line_bytes[31:16] <= vram_rdata;
                default: ;
            endcase
        end
    end

endmodule
